// File: rtl/mem_responder.sv
// CPU-facing memory responder: word RAM, a STATUS/TXDATA MMIO pair and a small output FIFO.
// MMIO side effects fire only on the rising edge of the CPU write request.
module mem_responder #(
  parameter int unsigned BITS_DATA  = 32,
  parameter int unsigned BITS_ADDR  = 16,
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITS_ADDR-1:0] MAR,
  input  logic [BITS_DATA-1:0] MBR_W,
  input  logic                 write,
  output logic [BITS_DATA-1:0] MBR_R,
  output logic [BITS_DATA-1:0] io_data,
  output logic                 io_valid,
  input  logic                 io_ready
);

  localparam int unsigned RamIdxW = $clog2(MEM_WORDS);
  localparam int unsigned IdxW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW    = IdxW + 1;

  localparam logic [BITS_ADDR-1:0] AddrTx     = '1;
  localparam logic [BITS_ADDR-1:0] AddrStatus = {{(BITS_ADDR-1){1'b1}}, 1'b0};
  localparam logic [BITS_ADDR:0]   MemLimit   = (BITS_ADDR+1)'(MEM_WORDS);

  logic [BITS_DATA-1:0] mem [MEM_WORDS];
  logic [BITS_DATA-1:0] fifo_q [FIFO_DEPTH];

  logic [BITS_DATA-1:0] mbr_r_q, mbr_r_d;
  logic                 write_q;
  logic                 armed_q, armed_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 ovf_q, ovf_d, err_q, err_d;

  logic                 is_tx, is_status, in_ram, unmapped;
  logic                 write_edge, full, empty, push_req, push, pop;
  logic [RamIdxW-1:0]   ram_idx;
  logic [BITS_DATA-1:0] rd_data;

  assign is_tx     = (MAR == AddrTx);
  assign is_status = (MAR == AddrStatus);
  assign in_ram    = ({1'b0, MAR} < MemLimit) && !is_tx && !is_status;
  assign unmapped  = !in_ram && !is_tx && !is_status;
  assign ram_idx   = MAR[RamIdxW-1:0];

  // armed_q blocks a write held across reset release from looking like a fresh edge.
  assign write_edge = write && !write_q && armed_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);

  assign io_valid = !empty;
  assign io_data  = fifo_q[rd_ptr_q[IdxW-1:0]];
  assign MBR_R    = mbr_r_q;

  assign pop      = io_valid && io_ready;
  assign push_req = write_edge && is_tx;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push     = push_req && (!full || pop);

  always_comb begin
    rd_data = '0;
    if (is_status) begin
      rd_data[4:0] = {1'b0, err_q, ovf_q, empty, full};
    end else if (in_ram) begin
      rd_data = mem[ram_idx];
    end
  end

  always_comb begin
    mbr_r_d  = write ? mbr_r_q : rd_data;
    armed_d  = armed_q || !write;
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    if (push_req && full && !pop) ovf_d = 1'b1;
    if (write_edge && unmapped)   err_d = 1'b1;
    if (write_edge && is_status) begin
      if (MBR_W[2]) ovf_d = 1'b0;
      if (MBR_W[3]) err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mbr_r_q  <= '0;
      write_q  <= 1'b0;
      armed_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      mbr_r_q  <= mbr_r_d;
      write_q  <= write;
      armed_q  <= armed_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // Storage is never reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset && write && in_ram) mem[ram_idx] <= MBR_W;
    if (reset && push) fifo_q[wr_ptr_q[IdxW-1:0]] <= MBR_W;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM path, FIFO fill/drain/wrap, MMIO status and reset.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] MAR;
  logic [31:0] MBR_W;
  logic        write;
  logic [31:0] MBR_R;
  logic [31:0] io_data;
  logic        io_valid;
  logic        io_ready;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [15:0] Status = 16'hFFFE;
  localparam logic [15:0] TxData = 16'hFFFF;

  mem_responder dut (
    .clk     (clk),
    .reset   (reset),
    .MAR     (MAR),
    .MBR_W   (MBR_W),
    .write   (write),
    .MBR_R   (MBR_R),
    .io_data (io_data),
    .io_valid(io_valid),
    .io_ready(io_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write edge followed by one idle (read) cycle.
  task automatic do_write(input logic [15:0] addr, input logic [31:0] data);
    MAR = addr; MBR_W = data; write = 1'b1;
    tick();
    write = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [15:0] addr, output logic [31:0] data);
    MAR = addr; write = 1'b0;
    tick();
    data = MBR_R;
  endtask

  logic [31:0] rd;

  initial begin
    reset = 1'b0; MAR = TxData; MBR_W = '0; write = 1'b0; io_ready = 1'b0;
    #12;
    check_eq("reset_mbr_r", MBR_R, 32'h0);
    check_eq("reset_valid", {31'b0, io_valid}, 32'h0);
    @(negedge clk); reset = 1'b1;
    tick();

    do_read(Status, rd);
    check_eq("status_idle", rd, 32'h02);

    // Read-after-write with write held three cycles
    do_read(TxData, rd);
    MAR = 16'h0010; MBR_W = 32'hDEADBEEF; write = 1'b1;
    tick(); tick(); tick();
    check_eq("mbr_r_hold_on_write", MBR_R, 32'h0);
    write = 1'b0;
    tick();
    check_eq("raw_read", MBR_R, 32'hDEADBEEF);

    // Fill and overflow
    for (int i = 1; i <= 5; i++) do_write(TxData, 32'(i));
    check_eq("fill_valid", {31'b0, io_valid}, 32'h1);
    check_eq("fill_head", io_data, 32'h1);
    do_read(Status, rd);
    check_eq("status_full_ovf", rd, 32'h05);
    check_eq("head_stable", io_data, 32'h1);

    // Drain
    MAR = TxData; io_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("drain_%0d", k), io_data, 32'(k));
      tick();
    end
    io_ready = 1'b0;
    check_eq("drain_empty", {31'b0, io_valid}, 32'h0);
    do_read(Status, rd);
    check_eq("status_empty_ovf", rd, 32'h06);
    do_write(Status, 32'h04);
    do_read(Status, rd);
    check_eq("ovf_w1c", rd, 32'h02);

    // Full push coincident with pop; pointers wrap here as well
    for (int i = 0; i < 4; i++) do_write(TxData, 32'h11 + 32'(i));
    MAR = TxData; MBR_W = 32'hAA; write = 1'b1; io_ready = 1'b1;
    check_eq("pp_head", io_data, 32'h11);
    tick();
    write = 1'b0; io_ready = 1'b0;
    do_read(Status, rd);
    check_eq("pp_status_full_no_ovf", rd, 32'h01);
    MAR = TxData; io_ready = 1'b1;
    check_eq("pp_drain_0", io_data, 32'h12); tick();
    check_eq("pp_drain_1", io_data, 32'h13); tick();
    check_eq("pp_drain_2", io_data, 32'h14); tick();
    check_eq("pp_drain_3", io_data, 32'hAA); tick();
    check_eq("pp_empty", {31'b0, io_valid}, 32'h0);

    // Push into empty with io_ready already high: no same-cycle pop
    MBR_W = 32'h55; write = 1'b1;
    tick();
    write = 1'b0;
    check_eq("pe_valid", {31'b0, io_valid}, 32'h1);
    check_eq("pe_data", io_data, 32'h55);
    tick();
    check_eq("pe_popped", {31'b0, io_valid}, 32'h0);
    io_ready = 1'b0;

    // Write held high pushes exactly once
    MAR = TxData; MBR_W = 32'h77; write = 1'b1;
    tick(); tick(); tick();
    write = 1'b0;
    tick();
    io_ready = 1'b1;
    check_eq("held_push_data", io_data, 32'h77);
    tick();
    check_eq("held_push_once", {31'b0, io_valid}, 32'h0);
    io_ready = 1'b0;

    // Unmapped write sets ERR, leaves RAM alone; W1C clears it
    do_write(16'h0000, 32'h0000CAFE);
    do_write(16'h8000, 32'h12345678);
    do_read(Status, rd);
    check_eq("err_set", rd, 32'h0A);
    do_read(16'h0000, rd);
    check_eq("ram_unchanged", rd, 32'h0000CAFE);
    do_read(16'h8000, rd);
    check_eq("unmapped_read", rd, 32'h0);
    do_write(Status, 32'h08);
    do_read(Status, rd);
    check_eq("err_w1c", rd, 32'h02);

    // Reset mid-operation
    do_write(TxData, 32'h1);
    do_write(TxData, 32'h2);
    do_read(16'h0010, rd);
    check_eq("pre_reset_mbr_r", MBR_R, 32'hDEADBEEF);
    #2 reset = 1'b0;
    #1;
    check_eq("async_valid", {31'b0, io_valid}, 32'h0);
    check_eq("async_mbr_r", MBR_R, 32'h0);
    // Hold a TXDATA write across reset release: must not count as an edge
    MAR = TxData; MBR_W = 32'h99; write = 1'b1;
    @(negedge clk); reset = 1'b1;
    tick(); tick();
    check_eq("held_over_reset", {31'b0, io_valid}, 32'h0);
    write = 1'b0;
    tick();
    write = 1'b1;
    tick();
    write = 1'b0;
    check_eq("edge_after_release", io_data, 32'h99);
    do_read(16'h0010, rd);
    check_eq("ram_retained", rd, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
